// File: rtl/cordic_vec_pipe.sv
// cordic_vec_pipe: fully pipelined vectoring CORDIC returning the vector length and the co-rotated companion x.
// Optional build macro CORDIC_GAIN_COMP_EN enables shift-add gain compensation in the final rank.
module cordic_vec_pipe #(
  parameter int W     = 16,
  parameter int STEPS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] xin_i,
  input  logic [W-1:0] yin_i,
  input  logic [W-1:0] x2in_i,
  input  logic [W-1:0] y2in_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] length_o,
  output logic [W-1:0] x2out_o
);
  localparam int DW = W + 2;
  typedef logic signed [DW-1:0] dw_t;

  logic         stall;
  dw_t          xe, x2e, x_p, x2_p;
  dw_t          x_a [STEPS], y_a [STEPS], x2_a [STEPS], y2_a [STEPS];
  dw_t          x_d [STEPS], y_d [STEPS], x2_d [STEPS], y2_d [STEPS];
  dw_t          x_q [STEPS], y_q [STEPS], x2_q [STEPS], y2_q [STEPS];
  logic         v_a [STEPS], v_q [STEPS];
  dw_t          xf, x2f, xc, x2c;
  logic [W-1:0] length_d, x2out_d, length_q, x2out_q;
  logic         out_valid_q;

  // A single global stall freezes every rank while the output is blocked.
  assign stall      = out_valid_q & ~out_ready_i;
  assign in_ready_o = ~stall;

  // Mirror into the right half-plane when x is negative; y and y2 are left alone.
  assign xe   = dw_t'($signed(xin_i));
  assign x2e  = dw_t'($signed(x2in_i));
  assign x_p  = xe[DW-1] ? -xe : xe;
  assign x2_p = xe[DW-1] ? -x2e : x2e;

  for (genvar s = 0; s < STEPS; s++) begin : g_step
    if (s == 0) begin : g_first
      assign v_a[s]  = in_valid_i;
      assign x_a[s]  = x_p;
      assign y_a[s]  = dw_t'($signed(yin_i));
      assign x2_a[s] = x2_p;
      assign y2_a[s] = dw_t'($signed(y2in_i));
    end else begin : g_next
      assign v_a[s]  = v_q[s-1];
      assign x_a[s]  = x_q[s-1];
      assign y_a[s]  = y_q[s-1];
      assign x2_a[s] = x2_q[s-1];
      assign y2_a[s] = y2_q[s-1];
    end
    // Micro-rotation by atan(2^-s); the sign of y alone steers both vectors.
    always_comb begin
      x_d[s]  = y_a[s][DW-1] ? x_a[s] - (y_a[s] >>> s)   : x_a[s] + (y_a[s] >>> s);
      y_d[s]  = y_a[s][DW-1] ? y_a[s] + (x_a[s] >>> s)   : y_a[s] - (x_a[s] >>> s);
      x2_d[s] = y_a[s][DW-1] ? x2_a[s] - (y2_a[s] >>> s) : x2_a[s] + (y2_a[s] >>> s);
      y2_d[s] = y_a[s][DW-1] ? y2_a[s] + (x2_a[s] >>> s) : y2_a[s] - (x2_a[s] >>> s);
    end
    // Rank valid bit: the only reset state inside the rotation ranks.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) v_q[s] <= 1'b0;
      else if (!stall) v_q[s] <= v_a[s];
    // Rank data: holds on stall, may carry stale values while invalid.
    always_ff @(posedge clk)
      if (!stall) begin
        x_q[s]  <= x_d[s];
        y_q[s]  <= y_d[s];
        x2_q[s] <= x2_d[s];
        y2_q[s] <= y2_d[s];
      end
  end

  assign xf  = x_q[STEPS-1];
  assign x2f = x2_q[STEPS-1];

`ifdef CORDIC_GAIN_COMP_EN
  // Shift-add gain correction: 0.625 for short pipes, 0.609375 from three steps on.
  always_comb begin
    xc  = (xf >>> 1) + (xf >>> 3) - ((STEPS >= 3) ? (xf >>> 6) : dw_t'(0));
    x2c = (x2f >>> 1) + (x2f >>> 3) - ((STEPS >= 3) ? (x2f >>> 6) : dw_t'(0));
  end
`else
  assign xc  = xf;
  assign x2c = x2f;
`endif

  // Length clamps to the unsigned W-bit range, companion x to the signed one.
  assign length_d = xc[DW-1] ? '0 : (|xc[DW-2:W]) ? '1 : xc[W-1:0];
  assign x2out_d  = (x2c[DW-1:W-1] == '0 || x2c[DW-1:W-1] == '1) ? x2c[W-1:0] :
                    {x2c[DW-1], {(W-1){~x2c[DW-1]}}};

  // Output rank: registered, reset to zero, frozen while stalled.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      length_q    <= '0;
      x2out_q     <= '0;
    end else if (!stall) begin
      out_valid_q <= v_q[STEPS-1];
      length_q    <= length_d;
      x2out_q     <= x2out_d;
    end

  assign out_valid_o = out_valid_q;
  assign length_o    = length_q;
  assign x2out_o     = x2out_q;
endmodule

// File: tb/tb_cordic_vec_pipe.sv
// tb_cordic_vec_pipe: random and directed stimulus on STEPS=2 and STEPS=4 instances checked against an integer model.
module tb_cordic_vec_pipe;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, out_ready;
  logic [W-1:0] xin, yin, x2in, y2in;
  logic         ir [2], ov [2];
  logic [W-1:0] len [2], x2o [2];

  int  total = 0, bad = 0, cyc = 0;
  bit  done = 1'b0, lit_on = 1'b0;
  int  lit_len [2], lit_x2 [2];
  int  e_len [2][64], e_x2 [2][64], a_cyc [2][64], a_stl [2][64], l_len [2][64], l_x2 [2][64];
  bit  l_on [2][64];
  int  wp [2], rp [2], stl [2];
  bit  pst [2];
  logic [W-1:0] plen [2], px2 [2];
  int  k, ml, mo, lat;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cordic_vec_pipe #(.W(W), .STEPS(g == 0 ? 2 : 4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(ir[g]),
      .xin_i(xin), .yin_i(yin), .x2in_i(x2in), .y2in_i(y2in),
      .out_valid_o(ov[g]), .out_ready_i(out_ready), .length_o(len[g]), .x2out_o(x2o[g])
    );
  end

  always #5 clk = ~clk;

  function automatic int steps_of(input int n);
    return n == 0 ? 2 : 4;
  endfunction

  // Plain integer CORDIC: fold, rotate, compensate, clamp.
  function automatic void model(input int xi, input int yi, input int ai, input int bi,
                                input int steps, output int l, output int o);
    int x = xi, y = yi, a = ai, b = bi, nx, ny, na, nb;
    if (x < 0) begin x = -x; a = -a; end
    for (int i = 0; i < steps; i++) begin
      if (y >= 0) begin nx = x + (y >>> i); ny = y - (x >>> i); na = a + (b >>> i); nb = b - (a >>> i); end
      else        begin nx = x - (y >>> i); ny = y + (x >>> i); na = a - (b >>> i); nb = b + (a >>> i); end
      x = nx; y = ny; a = na; b = nb;
    end
`ifdef CORDIC_GAIN_COMP_EN
    x = (x >>> 1) + (x >>> 3) - (steps >= 3 ? (x >>> 6) : 0);
    a = (a >>> 1) + (a >>> 3) - (steps >= 3 ? (a >>> 6) : 0);
`endif
    l = x < 0 ? 0 : (x > (1 << W) - 1 ? (1 << W) - 1 : x);
    o = a < -(1 << (W - 1)) ? -(1 << (W - 1)) : (a > (1 << (W - 1)) - 1 ? (1 << (W - 1)) - 1 : a);
  endfunction

  always @(negedge clk) begin
    cyc++;
    for (int n = 0; n < 2; n++) begin
      if (!rst_n) begin
        total++;
        if (ov[n] !== 1'b0 || len[n] !== '0 || x2o[n] !== '0) begin
          bad++;
          $display("FAIL reset_out inst%0d: valid=%b length=%0d x2out=%0d, required 0 0 0", n, ov[n], len[n], x2o[n]);
        end
        wp[n] = 0; rp[n] = 0; pst[n] = 1'b0; stl[n] = 0;
      end else begin
        total++;
        if (ir[n] !== !(ov[n] && !out_ready)) begin
          bad++;
          $display("FAIL in_ready inst%0d: got %b, required %b", n, ir[n], !(ov[n] && !out_ready));
        end
        if (pst[n]) begin
          total++;
          if (ov[n] !== 1'b1 || len[n] !== plen[n] || x2o[n] !== px2[n]) begin
            bad++;
            $display("FAIL stall_hold inst%0d: valid=%b length=%0d x2out=%0d, required 1 %0d %0d",
                     n, ov[n], len[n], x2o[n], plen[n], px2[n]);
          end
        end
        if (ov[n] && out_ready) begin
          total++;
          if (rp[n] == wp[n]) begin
            bad++;
            $display("FAIL spurious_out inst%0d: length=%0d x2out=%0d with no sample pending", n, len[n], x2o[n]);
          end else begin
            k = rp[n] % 64;
            if (int'(len[n]) != e_len[n][k] || int'($signed(x2o[n])) != e_x2[n][k]) begin
              bad++;
              $display("FAIL model inst%0d: length=%0d x2out=%0d, required %0d %0d",
                       n, len[n], $signed(x2o[n]), e_len[n][k], e_x2[n][k]);
            end
            total++;
            lat = cyc - a_cyc[n][k];
            if (lat != steps_of(n) + 1 + stl[n] - a_stl[n][k]) begin
              bad++;
              $display("FAIL latency inst%0d: got %0d, required %0d", n, lat, steps_of(n) + 1 + stl[n] - a_stl[n][k]);
            end
            if (l_on[n][k]) begin
              total++;
              if (int'(len[n]) != l_len[n][k] || int'($signed(x2o[n])) != l_x2[n][k]) begin
                bad++;
                $display("FAIL literal inst%0d: length=%0d x2out=%0d, required %0d %0d",
                         n, len[n], $signed(x2o[n]), l_len[n][k], l_x2[n][k]);
              end
            end
            rp[n]++;
          end
        end
        if (in_valid && !(ov[n] && !out_ready)) begin
          k = wp[n] % 64;
          model(int'($signed(xin)), int'($signed(yin)), int'($signed(x2in)), int'($signed(y2in)), steps_of(n), ml, mo);
          e_len[n][k] = ml; e_x2[n][k] = mo;
          a_cyc[n][k] = cyc; a_stl[n][k] = stl[n];
          l_on[n][k] = lit_on; l_len[n][k] = lit_len[n]; l_x2[n][k] = lit_x2[n];
          wp[n]++;
        end
        pst[n] = ov[n] && !out_ready;
        if (pst[n]) begin stl[n]++; plen[n] = len[n]; px2[n] = x2o[n]; end
      end
    end
    if (done) begin
      for (int n = 0; n < 2; n++) begin
        total++;
        if (rp[n] != wp[n]) begin
          bad++;
          $display("FAIL drain inst%0d: %0d samples never emerged, required 0", n, wp[n] - rp[n]);
        end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  function automatic logic [W-1:0] rnd();
    int r = $urandom_range(0, 7);
    return r == 0 ? {1'b1, {(W-1){1'b0}}} : r == 1 ? {1'b0, {(W-1){1'b1}}} : W'($urandom);
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand();
    xin = rnd(); yin = rnd(); x2in = rnd(); y2in = rnd();
  endtask

  task automatic lit(input int x, input int y, input int a, input int b,
                     input int l0, input int o0, input int l1, input int o1);
    lit_len[0] = l0; lit_x2[0] = o0; lit_len[1] = l1; lit_x2[1] = o1;
    xin = W'(x); yin = W'(y); x2in = W'(a); y2in = W'(b);
    lit_on = 1'b1; in_valid = 1'b1;
    next();
    lit_on = 1'b0; in_valid = 1'b0;
    repeat (7) next();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    xin = '0; yin = '0; x2in = '0; y2in = '0;
    repeat (3) next();
    rst_n = 1'b1;
    next();
`ifdef CORDIC_GAIN_COMP_EN
    lit(3000, 4000, 1000, 0, 4687, 312, 4999, 637);
    lit(-3000, 4000, 1000, 0, 4687, -313, 4999, -637);
    lit(-32768, -32768, 0, 0, 40960, 0, 46176, 0);
`else
    lit(3000, 4000, 1000, 0, 7500, 500, 8204, 1047);
    lit(-3000, 4000, 1000, 0, 7500, -500, 8204, -1046);
    lit(-32768, -32768, 0, 0, 65535, 0, 65535, 0);
`endif
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin drive_rand(); next(); end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin drive_rand(); next(); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin drive_rand(); next(); end
    rst_n = 1'b0;
    repeat (2) next();
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      drive_rand();
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      next();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) next();
    done = 1'b1;
    repeat (5) next();
    $display("FAIL watchdog: summary not reached");
    $fatal(1);
  end
endmodule
